// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU instruction sequencer and its op consumers.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_EX   = 2'b10,
    ST_WB   = 2'b11
  } seq_state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] alu_op;
    logic       legal;
  } decode_t;

  // An op code is executable only if the ALU implements it.
  function automatic logic op_supported(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: op_supported = 1'b1;
      default:                                    op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rtype_decoder.sv
// Combinational RISC-V R-type decoder: instruction word to register addresses, ALU op and legality.
module rtype_decoder
  import alu_seq_pkg::*;
(
  input  logic [31:0] instr,
  output decode_t     dec
);

  logic [6:0] funct7;
  logic [3:0] op;

  assign funct7 = instr[31:25];
  assign op     = {instr[30], instr[14:12]};

  // funct7 selects base vs alternate encodings; the op set then rules out alt forms other than SUB/SRA.
  always_comb begin
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.rd     = instr[11:7];
    dec.alu_op = op;
    dec.legal  = (instr[6:0] == OPC_RTYPE) &&
                 ((funct7 == F7_BASE) || (funct7 == F7_ALT)) &&
                 op_supported(op);
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Accepts R-type instructions and steps the register-file/ALU datapath through read, execute, write-back.
// Optional macro ALU_SEQ_FLAG_CAPTURE_EN builds the ALU flag capture register behind flags_q.
module alu_instr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [31:0]         in_instr,
  output logic                in_ready,
  input  logic [3:0]          alu_flags,
  output logic [4:0]          r_addr_a,
  output logic [4:0]          r_addr_b,
  output logic [4:0]          w_addr,
  output logic [3:0]          alu_op,
  output logic                w_en,
  output logic                reg_clk,
  output logic                alu_clk,
  output logic                done,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          flags_q
);

  seq_state_t state_q, state_d;
  logic [31:0] instr_q;
  decode_t     dec_q, dec_in;
  logic        accept, write_ok;
  logic        reg_clk_d, alu_clk_d, w_en_d, done_d, illegal_d;

  // The latched copy drives the datapath; the live decode only decides the first read strobe.
  rtype_decoder u_dec_q  (.instr(instr_q),  .dec(dec_q));
  rtype_decoder u_dec_in (.instr(in_instr), .dec(dec_in));

  logic unused_dec_in;
  assign unused_dec_in = ^{dec_in.rs1, dec_in.rs2, dec_in.rd, dec_in.alu_op};

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign write_ok = dec_q.legal && (dec_q.rd != 5'd0);
  assign r_addr_a = dec_q.rs1;
  assign r_addr_b = dec_q.rs2;
  assign w_addr   = dec_q.rd;
  assign alu_op   = dec_q.alu_op;

  // Strobe values are computed for the state being entered so they appear as flop outputs there.
  always_comb begin
    state_d   = state_q;
    reg_clk_d = 1'b0;
    alu_clk_d = 1'b0;
    w_en_d    = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_RD;
          reg_clk_d = dec_in.legal;
        end
      end
      ST_RD: begin
        state_d   = ST_EX;
        alu_clk_d = dec_q.legal;
        w_en_d    = write_ok;
      end
      ST_EX: begin
        state_d   = ST_WB;
        reg_clk_d = dec_q.legal;
        w_en_d    = write_ok;
      end
      ST_WB: begin
        state_d   = ST_IDLE;
        done_d    = 1'b1;
        illegal_d = !dec_q.legal;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      reg_clk <= 1'b0;
      alu_clk <= 1'b0;
      w_en    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_clk <= reg_clk_d;
      alu_clk <= alu_clk_d;
      w_en    <= w_en_d;
      done    <= done_d;
      illegal <= illegal_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= 32'd0;
      retired <= '0;
    end else begin
      if (accept) begin
        instr_q <= in_instr;
      end
      if (state_q == ST_WB && dec_q.legal) begin
        retired <= retired + RETIRE_W'(1);
      end
    end
  end

`ifdef ALU_SEQ_FLAG_CAPTURE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'd0;
    end else if (state_q == ST_WB && dec_q.legal) begin
      flags_q <= alu_flags;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = ^alu_flags;
  assign flags_q      = 4'd0;
`endif

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench for alu_instr_sequencer: instruction-level model compared every cycle plus pinned literals.
module tb_alu_instr_sequencer;

  localparam int RW = 3;

  localparam logic [31:0] I_ADD3   = 32'h002081B3;
  localparam logic [31:0] I_SUB5   = 32'h407302B3;
  localparam logic [31:0] I_ADDX0  = 32'h00208033;
  localparam logic [31:0] I_ILL    = 32'h00208013;
  localparam logic [31:0] I_XOR10  = 32'h00C5C533;
  localparam logic [31:0] I_OR7    = 32'h009463B3;
  localparam logic [31:0] I_SRA4   = 32'h40125233;
  localparam logic [31:0] I_ILLALT = 32'h4020F1B3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic [3:0]    alu_flags;
  logic [4:0]    r_addr_a, r_addr_b, w_addr;
  logic [3:0]    alu_op;
  logic          w_en, reg_clk, alu_clk, done, illegal;
  logic [RW-1:0] retired;
  logic [3:0]    flags_q;

  int checks = 0;
  int errors = 0;
  bit checkOn = 0;

  alu_instr_sequencer #(.RETIRE_W(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .alu_flags(alu_flags), .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .w_addr(w_addr),
    .alu_op(alu_op), .w_en(w_en), .reg_clk(reg_clk), .alu_clk(alu_clk), .done(done),
    .illegal(illegal), .retired(retired), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  // Legal = R-type opcode with funct7 zero, or funct7 0x20 only for SUB (f3=0) and SRA (f3=5).
  function automatic bit modelLegal(input logic [31:0] i);
    if (i[6:0] != 7'h33) return 1'b0;
    if (i[31:25] == 7'h00) return 1'b1;
    if (i[31:25] == 7'h20 && (i[14:12] == 3'd0 || i[14:12] == 3'd5)) return 1'b1;
    return 1'b0;
  endfunction

  // Model: cycles since accept (1=read, 2=execute, 3=write-back), retire/flag bookkeeping at completion.
  int            phase = 0;
  logic [31:0]   m_instr = 32'd0;
  logic [RW-1:0] m_retired = '0;
  logic [3:0]    m_flags = 4'd0;
  bit            m_done = 0;
  bit            m_illegal = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= 0;
      m_instr   <= 32'd0;
      m_retired <= '0;
      m_flags   <= 4'd0;
      m_done    <= 0;
      m_illegal <= 0;
    end else begin
      m_done    <= (phase == 3);
      m_illegal <= (phase == 3) && !modelLegal(m_instr);
      if (phase == 3) begin
        if (modelLegal(m_instr)) begin
          m_retired <= m_retired + 1'b1;
          m_flags   <= alu_flags;
        end
        phase <= 0;
      end else if (phase != 0) begin
        phase <= phase + 1;
      end else if (in_valid) begin
        m_instr <= in_instr;
        phase   <= 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      bit lg;
      lg = modelLegal(m_instr);
      checkOutput("in_ready", in_ready, phase == 0);
      checkOutput("r_addr_a", r_addr_a, m_instr[19:15]);
      checkOutput("r_addr_b", r_addr_b, m_instr[24:20]);
      checkOutput("w_addr",   w_addr,   m_instr[11:7]);
      checkOutput("alu_op",   alu_op,   {m_instr[30], m_instr[14:12]});
      checkOutput("reg_clk",  reg_clk,  lg && (phase == 1 || phase == 3));
      checkOutput("alu_clk",  alu_clk,  lg && phase == 2);
      checkOutput("w_en",     w_en,     lg && m_instr[11:7] != 5'd0 && (phase == 2 || phase == 3));
      checkOutput("done",     done,     m_done);
      checkOutput("illegal",  illegal,  m_illegal);
      checkOutput("retired",  retired,  m_retired);
`ifdef ALU_SEQ_FLAG_CAPTURE_EN
      checkOutput("flags_q",  flags_q,  m_flags);
`else
      checkOutput("flags_q",  flags_q,  32'd0);
`endif
    end
  end

  // Called at a negedge; waits (bounded) for in_ready, then holds valid across one accept edge.
  task automatic applyStimulus(input logic [31:0] instr, input logic [3:0] flags);
    int waitCount = 0;
    while (!in_ready && waitCount < 20) begin
      @(negedge clk);
      waitCount++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready got 0 expected 1 at %0t", $time);
    end
    in_valid  = 1'b1;
    in_instr  = instr;
    alu_flags = flags;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; alu_flags = 4'd0;
    repeat (2) @(negedge clk);
    checkOn = 1;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_retired", retired, 0);
    checkOutput("reset_w_en", w_en, 0);
    rst = 1'b0;
    @(negedge clk);

    // ADD x3,x1,x2 with per-cycle strobe pins
    applyStimulus(I_ADD3, 4'b0000);
    @(negedge clk);
    checkOutput("add_c1_reg_clk", reg_clk, 1);
    checkOutput("add_c1_w_en", w_en, 0);
    checkOutput("add_rs1", r_addr_a, 1);
    checkOutput("add_rs2", r_addr_b, 2);
    checkOutput("add_rd", w_addr, 3);
    @(negedge clk);
    checkOutput("add_c2_alu_clk", alu_clk, 1);
    checkOutput("add_c2_w_en", w_en, 1);
    @(negedge clk);
    checkOutput("add_c3_reg_clk", reg_clk, 1);
    checkOutput("add_c3_w_en", w_en, 1);
    @(negedge clk);
    checkOutput("add_c4_done", done, 1);
    checkOutput("add_c4_retired", retired, 1);
    checkOutput("add_alu_op", alu_op, 4'b0000);

    // SUB back-to-back on the done edge
    applyStimulus(I_SUB5, 4'b0011);
    @(negedge clk);
    checkOutput("sub_alu_op", alu_op, 4'b1000);
    repeat (3) @(negedge clk);
    checkOutput("sub_retired", retired, 2);

    // rd = x0, flags 1010 captured
    applyStimulus(I_ADDX0, 4'b1010);
    repeat (4) @(negedge clk);
    checkOutput("x0_retired", retired, 3);
`ifdef ALU_SEQ_FLAG_CAPTURE_EN
    checkOutput("x0_flags", flags_q, 4'b1010);
`else
    checkOutput("x0_flags", flags_q, 4'b0000);
`endif

    // I-type opcode rejected; flags held
    applyStimulus(I_ILL, 4'b0101);
    repeat (4) @(negedge clk);
    checkOutput("ill_done", done, 1);
    checkOutput("ill_illegal", illegal, 1);
    checkOutput("ill_retired", retired, 3);
`ifdef ALU_SEQ_FLAG_CAPTURE_EN
    checkOutput("ill_flags", flags_q, 4'b1010);
`else
    checkOutput("ill_flags", flags_q, 4'b0000);
`endif

    // XOR while in_valid stays high with OR pending; OR must wait for IDLE
    applyStimulus(I_XOR10, 4'b0001);
    in_valid = 1'b1;
    in_instr = I_OR7;
    repeat (4) @(negedge clk);
    checkOutput("xor_rd_held", w_addr, 10);
    checkOutput("xor_alu_op", alu_op, 4'b0100);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checkOutput("or_rd", w_addr, 7);
    checkOutput("or_alu_op", alu_op, 4'b0110);
    repeat (3) @(negedge clk);
    checkOutput("or_retired", retired, 5);

    applyStimulus(I_SRA4, 4'b0000);
    @(negedge clk);
    checkOutput("sra_alu_op", alu_op, 4'b1101);
    repeat (3) @(negedge clk);
    checkOutput("sra_retired", retired, 6);

    // funct7 0x20 with AND funct3 is illegal
    applyStimulus(I_ILLALT, 4'b0000);
    repeat (4) @(negedge clk);
    checkOutput("illalt_illegal", illegal, 1);
    checkOutput("illalt_retired", retired, 6);

    // Reset while in EX
    applyStimulus(I_ADD3, 4'b0000);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstex_in_ready", in_ready, 1);
    checkOutput("rstex_alu_clk", alu_clk, 0);
    checkOutput("rstex_w_en", w_en, 0);
    checkOutput("rstex_retired", retired, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    applyStimulus(I_ADD3, 4'b0000);
    repeat (4) @(negedge clk);
    checkOutput("post_rst_done", done, 1);
    checkOutput("post_rst_retired", retired, 1);

    // Eight more retirements wrap the 3-bit counter back to 1
    for (int n = 0; n < 8; n++) begin
      applyStimulus(I_ADD3, 4'b0000);
      repeat (4) @(negedge clk);
    end
    checkOutput("wrap_retired", retired, 1);

    repeat (2) @(negedge clk);
    checkOn = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_instr_sequencer.md
# alu_instr_sequencer

Front-end control stage that drives the register-file-plus-ALU datapath. It accepts 32-bit RISC-V R-type instructions over a valid/ready handshake and decodes them into register addresses, a 4-bit ALU op, and write enable. It then generates the one-cycle `reg_clk` and `alu_clk` strobes that step the datapath through read, execute and write-back.

## Interface
- `RETIRE_W`, 32: width of the retired-instruction counter.
- `clk  in  1`: single system clock, all state on its rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `in_valid  in  1`: instruction present on `in_instr`.
- `in_instr  in  32`: RISC-V instruction word.
- `in_ready  out  1`: sequencer can accept an instruction; high only in IDLE.
- `alu_flags  in  4`: flags from the ALU, sampled at write-back.
- `r_addr_a  out  5`: rs1 (`instr[19:15]`), held from accept until return to IDLE.
- `r_addr_b  out  5`: rs2 (`instr[24:20]`), held likewise.
- `w_addr  out  5`: rd (`instr[11:7]`), held likewise.
- `alu_op  out  4`: `{instr[30], instr[14:12]}`, held likewise.
- `w_en  out  1`: register write enable.
- `reg_clk  out  1`: register-file strobe, registered one-cycle pulse.
- `alu_clk  out  1`: ALU strobe, registered one-cycle pulse.
- `done  out  1`: one-cycle pulse when an instruction retires or is rejected.
- `illegal  out  1`: one-cycle pulse, coincident with `done`, for a rejected instruction.
- `retired  out  RETIRE_W`: count of legally executed instructions, wraps modulo 2^RETIRE_W.
- `flags_q  out  4`: latched ALU flags of the last legal instruction.

## Operation
- FSM states: IDLE, RD, EX, WB.
- IDLE → RD on `in_valid && in_ready`.
  - The instruction is latched.
  - Decode fields are driven from the latched copy.
- RD → EX → WB → IDLE unconditionally, one cycle each.
- Legal instruction: opcode `7'b0110011` and one of:
  - funct7 = `7'b0000000`;
  - funct7 = `7'b0100000` with funct3 ∈ {000, 101}.
- Anything else is illegal.
  - The sequence still runs, with `reg_clk` and `alu_clk` pulses suppressed and `w_en` held 0.
  - `done` and `illegal` pulse on the WB→IDLE edge.
- ALU op codes:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011;
  - XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- rd = x0: `w_en` stays 0 for the whole instruction.
  - The instruction still counts as retired.
  - `flags_q` still updates.
- `retired` increments by 1 on the WB→IDLE edge of each legal instruction.
  - Wraps from all-ones to 0.
- Reset values:
  - outputs: all 0 except `in_ready` = 1;
  - FSM: IDLE;
  - latched instruction: 0.
- Reset mid-sequence: the instruction is abandoned, no write occurs, `done` does not pulse.

## Timing
- Cycle 0: accept edge.
- Cycle 1 (RD): `reg_clk` = 1, `w_en` = 0.
- Cycle 2 (EX): `alu_clk` = 1, `w_en` = 1 if legal and rd ≠ 0.
- Cycle 3 (WB): `reg_clk` = 1 and `w_en` unchanged, so `w_en` is stable before the `reg_clk` rising edge. `alu_flags` is sampled at the end of WB.
- Cycle 4 (IDLE): `done` = 1, `in_ready` = 1.
  - A new instruction may be accepted on this edge, so back-to-back throughput is one instruction per 4 cycles.
- `in_ready` is 0 in RD, EX and WB; `in_valid` during those states is ignored and not consumed.
- Every strobe is a flop output; no combinational path from inputs to `reg_clk`, `alu_clk` or `w_en`.

## Configuration
- `ALU_SEQ_FLAG_CAPTURE_EN` defined: `flags_q` holds `alu_flags` sampled in WB of each legal instruction.
- Macro undefined:
  - `flags_q` is tied to 4'b0;
  - `alu_flags` is unused;
  - no capture register is built.

## Structure
- Shared package `alu_seq_pkg` contains:
  - FSM state encoding (2-bit: IDLE 00, RD 01, EX 10, WB 11);
  - ALU op constants above;
  - `OPC_RTYPE`, `F7_BASE`, `F7_ALT`.
- The ALU and any other op consumer import the same op constants.
- One sub-module: `rtype_decoder`, combinational, instruction → {rs1, rs2, rd, alu_op, legal}.

## Test plan
- ADD x3,x1,x2 (`32'h002081B3`):
  - `r_addr_a`=1, `r_addr_b`=2, `w_addr`=3, `alu_op`=0000;
  - strobes in cycles 1/2/3, `w_en` high cycles 2–3, `done` at cycle 4, `retired`=1.
- SUB x5,x6,x7 (`32'h407302B3`) immediately after `done`:
  - accepted on the `done` edge, `alu_op`=1000, `retired`=2.
- ADD x0,x1,x2 (`32'h00208033`):
  - `w_en` 0 throughout, both strobes still pulse, `retired` increments.
- Illegal instruction (`32'h00208013`, I-type opcode):
  - no `reg_clk`/`alu_clk`/`w_en`, `done`=`illegal`=1 at cycle 4, `retired` unchanged.
- `rst` asserted in EX:
  - outputs 0 and `in_ready`=1 immediately;
  - no `done`, no `w_en`, the next instruction runs normally.
- `ALU_SEQ_FLAG_CAPTURE_EN` with `alu_flags`=4'b1010 in WB:
  - `flags_q`=1010 at cycle 4, held through a following illegal instruction;
  - with the macro undefined, `flags_q`=0.
